// File: rtl/dmem_ctrl.sv
// ============================================================================
// dmem_ctrl : word-organised data memory controller, valid/ready request port,
//             byte-lane stores, optional wait states. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int ADDR_W   = 6,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] c_CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        w_access;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mask;

    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] r_mem [c_DEPTH];

    logic              w_accept;
    logic              w_acc_we;
    logic [31:0]       w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic [3:0]        w_acc_mask;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_old;
    logic [31:0]       w_merged;

    assign req_ready = (r_state == S_IDLE);
    assign w_accept  = (r_state == S_IDLE) && req_valid;

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    assign w_acc_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_acc_mask  = (r_state == S_IDLE) ? req_mask  : r_mask;

    assign w_err = (w_acc_addr[1:0] != 2'b00) || (|w_acc_addr[31:ADDR_W+2]);
    assign w_idx = w_acc_addr[ADDR_W+1:2];
    assign w_old = r_mem[w_idx];

    always_comb begin
        w_merged = w_old;
        for (int b = 0; b < 4; b++) begin
            if (w_acc_mask[b]) begin
                w_merged[8*b +: 8] = w_acc_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYC == 0) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_cnt_nxt   = c_CNT_INIT;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rsp_valid <= w_access;
            if (w_access) begin
                r_rsp_err   <= w_err;
                r_rsp_rdata <= w_err ? 32'd0 : (w_acc_we ? w_merged : w_old);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mask  <= req_mask;
        end
    end

    // Reset gates the write so a request caught in WAIT leaves memory intact.
    always_ff @(posedge clk) begin
        if (rst && w_access && w_acc_we && !w_err) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// tb_dmem_ctrl : randomized self-checking bench for dmem_ctrl (WAIT_CYC 0 and 3)
//                against a transaction-level memory model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        v      [2];
    logic        we     [2];
    logic [31:0] addr   [2];
    logic [31:0] wd     [2];
    logic [3:0]  mk     [2];
    logic        ready  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        rerr   [2];

    dmem_ctrl #(.ADDR_W(6), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .req_valid(v[0]), .req_we(we[0]),
        .req_addr(addr[0]), .req_wdata(wd[0]), .req_mask(mk[0]),
        .req_ready(ready[0]), .rsp_valid(rvalid[0]), .rsp_rdata(rdata[0]),
        .rsp_err(rerr[0])
    );

    dmem_ctrl #(.ADDR_W(6), .WAIT_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .req_valid(v[1]), .req_we(we[1]),
        .req_addr(addr[1]), .req_wdata(wd[1]), .req_mask(mk[1]),
        .req_ready(ready[1]), .rsp_valid(rvalid[1]), .rsp_rdata(rdata[1]),
        .rsp_err(rerr[1])
    );

    // Transaction model: word array, busy countdown, pending access countdown.
    bit [31:0] mem_m [2][64];
    int        busy [2];
    int        acc [2];
    int        acc_cnt [2];
    bit        pend [2];
    bit        ev [2];
    bit        ee [2];
    bit [31:0] er [2];
    bit        q_we [2];
    bit [31:0] q_a [2];
    bit [31:0] q_d [2];
    bit [3:0]  q_m [2];
    bit        started [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    function automatic int wc(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic void perform(int k);
        bit [31:0] w;
        ev[k] = 1'b1;
        if (q_a[k][1:0] != 2'b00 || q_a[k][31:8] != 24'd0) begin
            ee[k] = 1'b1;
            er[k] = 32'd0;
        end else begin
            ee[k] = 1'b0;
            w = mem_m[k][q_a[k][7:2]];
            if (q_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (q_m[k][b]) w[8*b +: 8] = q_d[k][8*b +: 8];
                mem_m[k][q_a[k][7:2]] = w;
            end
            er[k] = w;
        end
    endfunction

    always @(posedge clk) begin : p_model
        bit rb;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                busy[k] = 0;
                pend[k] = 1'b0;
                ev[k]   = 1'b0;
                ee[k]   = 1'b0;
                er[k]   = 32'd0;
            end else begin
                rb    = (busy[k] == 0);
                ev[k] = 1'b0;
                if (busy[k] > 0) busy[k]--;
                if (pend[k]) begin
                    acc[k]--;
                    if (acc[k] == 0) begin
                        perform(k);
                        pend[k] = 1'b0;
                    end
                end
                if (rb && v[k]) begin
                    q_we[k] = we[k];
                    q_a[k]  = addr[k];
                    q_d[k]  = wd[k];
                    q_m[k]  = mk[k];
                    acc_cnt[k]++;
                    busy[k] = wc(k) + 1;
                    if (wc(k) == 0) perform(k);
                    else begin
                        pend[k] = 1'b1;
                        acc[k]  = wc(k);
                    end
                end
            end
        end
    end

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", n, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (started[k]) begin
                chk($sformatf("req_ready[%0d]", k), 32'(ready[k]), 32'(busy[k] == 0));
                chk($sformatf("rsp_valid[%0d]", k), 32'(rvalid[k]), 32'(ev[k]));
                chk($sformatf("rsp_rdata[%0d]", k), rdata[k], er[k]);
                chk($sformatf("rsp_err[%0d]", k), 32'(rerr[k]), 32'(ee[k]));
            end
        end
    endtask

    task automatic reset_inst(int k);
        v[k]     = 1'b0;
        rst_n[k] = 1'b0;
        tick();
        tick();
        rst_n[k]   = 1'b1;
        started[k] = 1'b1;
    endtask

    // Leaves req_valid high after acceptance so callers can chain requests.
    task automatic do_req(int k, bit we_i, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        int n0;
        int w;
        v[k]    = 1'b1;
        we[k]   = we_i;
        addr[k] = a;
        wd[k]   = d;
        mk[k]   = m;
        n0 = acc_cnt[k];
        w  = 0;
        while (acc_cnt[k] == n0 && w < 40) begin
            tick();
            w++;
        end
        if (acc_cnt[k] == n0) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(int k, output int lat);
        lat = 0;
        while (!rvalid[k] && lat < 40) begin
            tick();
            lat++;
        end
        if (!rvalid[k]) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(int k);
        v[k] = 1'b0;
        repeat (8) tick();
    endtask

    task automatic init_mem(int k);
        for (int i = 0; i < 64; i++) do_req(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
        drain(k);
    endtask

    task automatic rand_run(int k, int n);
        int          r;
        int          idx;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r   = $urandom_range(0, 9);
            idx = $urandom_range(0, 63);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(idx * 4) | 32'($urandom_range(1, 3));
            else             a = 32'(idx * 4);
            do_req(k, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 2) == 0) begin
                v[k] = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
            end
        end
        drain(k);
    endtask

    initial begin
        int lat;
        int lows;
        int t0;
        int t1;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; v[k] = 1'b0; we[k] = 1'b0;
            addr[k] = 32'd0; wd[k] = 32'd0; mk[k] = 4'd0;
        end

        // ---------------- WAIT_CYC = 0 ----------------
        reset_inst(0);
        chk("reset_ready0", 32'(ready[0]), 32'd1);
        chk("reset_rdata0", rdata[0], 32'd0);
        init_mem(0);

        do_req(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("store_latency0", 32'(lat), 32'd0);
        chk("store_rdata", rdata[0], 32'hDEADBEEF);
        do_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("load_rdata", rdata[0], 32'hDEADBEEF);
        chk("load_err", 32'(rerr[0]), 32'd0);

        do_req(0, 1'b1, 32'h8, 32'h11223344, 4'hF);
        do_req(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'h5);
        do_req(0, 1'b0, 32'h8, 32'h0, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("lane_merge", rdata[0], 32'h11BB33DD);

        do_req(0, 1'b0, 32'h6, 32'h0, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("misalign_err", 32'(rerr[0]), 32'd1);
        chk("misalign_rdata", rdata[0], 32'd0);

        do_req(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF);
        do_req(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("range_err", 32'(rerr[0]), 32'd1);
        do_req(0, 1'b0, 32'h0, 32'h0, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("range_no_write", rdata[0], 32'h0BADC0DE);

        do_req(0, 1'b1, 32'hC, 32'h12345678, 4'hF);
        do_req(0, 1'b1, 32'hC, 32'hFFFFFFFF, 4'h0);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("mask0_rdata", rdata[0], 32'h12345678);
        chk("mask0_err", 32'(rerr[0]), 32'd0);
        do_req(0, 1'b0, 32'hC, 32'h0, 4'hF);
        v[0] = 1'b0;
        wait_rsp(0, lat);
        chk("mask0_load", rdata[0], 32'h12345678);

        rand_run(0, 300);

        // ---------------- WAIT_CYC = 3 ----------------
        reset_inst(1);
        init_mem(1);

        do_req(1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF);
        t0   = cyc;
        lows = 0;
        lat  = -1;
        for (int i = 0; i < 8 && !ready[1]; i++) begin
            if (rvalid[1] && lat < 0) lat = i;
            lows++;
            tick();
        end
        chk("wait_ready_low", 32'(lows), 32'd4);
        chk("wait_latency", 32'(lat), 32'd3);
        do_req(1, 1'b1, 32'h10, 32'h12345A5A, 4'h3);
        t1 = cyc;
        chk("b2b_gap1", 32'(t1 - t0), 32'd5);
        do_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
        chk("b2b_gap2", 32'(cyc - t1), 32'd5);
        v[1] = 1'b0;
        wait_rsp(1, lat);
        chk("b2b_load", rdata[1], 32'hA5A55A5A);
        drain(1);

        do_req(1, 1'b1, 32'h4, 32'h01020304, 4'hF);
        v[1] = 1'b0;
        wait_rsp(1, lat);
        drain(1);
        do_req(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF);
        v[1] = 1'b0;
        tick();
        rst_n[1] = 1'b0;
        tick();
        rst_n[1] = 1'b1;
        chk("midrst_ready", 32'(ready[1]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_rsp", 32'(rvalid[1]), 32'd0);
            tick();
        end
        do_req(1, 1'b0, 32'h4, 32'h0, 4'hF);
        v[1] = 1'b0;
        wait_rsp(1, lat);
        chk("midrst_no_write", rdata[1], 32'h01020304);

        rand_run(1, 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
